// File: rtl/gon_mcc_buffered_if.sv
// Upstream/downstream handshake bundle for the GON multicast controller.
// The slave side belongs to the controller; the master side drives it.
interface gon_mcc_buffered_if #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4
) ();
  logic [DATA_WIDTH-1:0] data_in;
  logic [TAG_WIDTH-1:0]  tag;
  logic                  enable_in;
  logic                  ready_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  enable_out;
  logic                  ready_in;

  modport slave (
    input  data_in,
    input  tag,
    input  enable_in,
    input  ready_in,
    output ready_out,
    output data_out,
    output enable_out
  );

  modport master (
    output data_in,
    output tag,
    output enable_in,
    output ready_in,
    input  ready_out,
    input  data_out,
    input  enable_out
  );
endinterface

// File: rtl/gon_mcc_buffered.sv
// GON multicast controller with an output FIFO.
// Packets whose tag matches the scan-loaded {en, mask, id} under the mask are
// queued and forwarded downstream; all other packets are acknowledged and
// dropped. The FIFO isolates downstream back-pressure from the shared bus.
module gon_mcc_buffered #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             link_clk,
  input  logic                             reset,
  gon_mcc_buffered_if.slave                bus,
  input  logic                             se_id,
  input  logic                             si_id,
  output logic                             so_id,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level
);

  localparam int CFG_WIDTH = 2*TAG_WIDTH + 1;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W     = $clog2(FIFO_DEPTH+1);

  // Scan configuration: {cfg_en, cfg_mask, cfg_id}
  logic [CFG_WIDTH-1:0]  r_cfg;

  // FIFO state
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;

  logic                  w_cfg_en;
  logic [TAG_WIDTH-1:0]  w_cfg_mask;
  logic [TAG_WIDTH-1:0]  w_cfg_id;
  logic                  w_match;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_ready;
  logic                  w_push;
  logic                  w_pop;
  logic [PTR_W-1:0]      w_wr_next;
  logic [PTR_W-1:0]      w_rd_next;

  assign w_cfg_en   = r_cfg[CFG_WIDTH-1];
  assign w_cfg_mask = r_cfg[2*TAG_WIDTH-1:TAG_WIDTH];
  assign w_cfg_id   = r_cfg[TAG_WIDTH-1:0];

  assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);

  // Tag match, upstream ready and the push/pop strobes
  always_comb begin
    w_match = w_cfg_en && ((bus.tag & w_cfg_mask) == (w_cfg_id & w_cfg_mask));
    w_ready = 1'b0;
    if (!se_id) begin
      w_ready = !w_match || !w_full;
    end
    // ready is already low during scan, so pushes never see a partial cfg
    w_push = bus.enable_in && w_ready && w_match;
    w_pop  = !w_empty && bus.ready_in;
  end

  // Pointer increments wrap explicitly so any depth works, not just 2^n
  always_comb begin
    w_wr_next = (r_wr_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + PTR_W'(1);
    w_rd_next = (r_rd_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + PTR_W'(1);
  end

  // Configuration shift register, loaded MSB-first-in so cfg_id[0] exits first
  always_ff @(posedge link_clk or posedge reset) begin
    if (reset) begin
      r_cfg <= '0;
    end else if (se_id) begin
      r_cfg <= {si_id, r_cfg[CFG_WIDTH-1:1]};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge link_clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_next;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Payload storage; contents are never observed while empty, so no reset
  always_ff @(posedge link_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.data_in;
    end
  end

  assign bus.ready_out  = w_ready;
  assign bus.enable_out = !w_empty;
  assign bus.data_out   = w_empty ? '0 : r_mem[r_rd_ptr];
  assign so_id          = r_cfg[0];
  assign level          = r_level;

endmodule

// File: tb/tb_gon_mcc_buffered.sv
// Scoreboard bench for gon_mcc_buffered: a queue model of the spec's
// match/drop/FIFO rules, fed by an input watcher and drained by an output monitor.
module tb_gon_mcc_buffered;
  localparam int DW    = 64;
  localparam int TW    = 4;
  localparam int DEPTH = 3;
  localparam int LW    = $clog2(DEPTH+1);
  localparam int CW    = 2*TW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          se_id;
  logic          si_id;
  logic          so_id;
  logic [LW-1:0] level;

  gon_mcc_buffered_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  gon_mcc_buffered #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
    .link_clk (clk),
    .reset    (rst),
    .bus      (bus),
    .se_id    (se_id),
    .si_id    (si_id),
    .so_id    (so_id),
    .level    (level)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [CW-1:0] m_cfg;
  bit            do_push = 1'b0;
  bit            do_pop  = 1'b0;
  logic [DW-1:0] push_data;
  logic [DW-1:0] popped;
  int            rdy_mode = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_match(input logic [TW-1:0] t);
    logic          en;
    logic [TW-1:0] mask;
    logic [TW-1:0] id;
    en   = m_cfg[CW-1];
    mask = m_cfg[2*TW-1:TW];
    id   = m_cfg[TW-1:0];
    return en && ((t & mask) == (id & mask));
  endfunction

  function automatic bit model_ready();
    return !se_id && (!model_match(bus.tag) || exp_q.size() < DEPTH);
  endfunction

  // downstream ready pattern: 0 = stalled, 1 = always ready, else random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.ready_in = 1'b0;
      1:       bus.ready_in = 1'b1;
      default: bus.ready_in = 1'($urandom_range(0, 1));
    endcase
  end

  // input watcher: check ready_out and record accepted matching packets
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_out", DW'(bus.ready_out), DW'(model_ready()));
      do_push   = bus.enable_in && model_ready() && model_match(bus.tag);
      push_data = bus.data_in;
    end
  end

  always @(posedge clk) begin
    if (!rst && do_push) begin
      exp_q.push_back(push_data);
      do_push = 1'b0;
    end
  end

  // output monitor: compare the presented head against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      check("level", DW'(level), DW'(exp_q.size()));
      check("enable_out", DW'(bus.enable_out), DW'(exp_q.size() != 0));
      check("data_out", bus.data_out, (exp_q.size() != 0) ? exp_q[0] : '0);
      do_pop = (exp_q.size() != 0) && bus.ready_in;
    end
  end

  always @(posedge clk) begin
    if (!rst && do_pop) begin
      popped = exp_q.pop_front();
      do_pop = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // offer one packet until the model says it is accepted (bounded)
  task automatic send(input logic [TW-1:0] t, input logic [DW-1:0] d);
    bus.enable_in = 1'b1;
    bus.tag       = t;
    bus.data_in   = d;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (model_ready()) begin
        @(posedge clk);
        #1;
        bus.enable_in = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: tag %h data %h never accepted", t, d);
    bus.enable_in = 1'b0;
  endtask

  // shift in {en, mask, id}, id[0] first, checking so_id on the way
  task automatic scan(input logic en, input logic [TW-1:0] mask, input logic [TW-1:0] id);
    logic [CW-1:0] v;
    v = {en, mask, id};
    for (int i = 0; i < CW; i++) begin
      se_id = 1'b1;
      si_id = v[i];
      @(negedge clk);
      check("so_id", DW'(so_id), DW'(m_cfg[0]));
      @(posedge clk);
      m_cfg = {si_id, m_cfg[CW-1:1]};
      #1;
    end
    se_id = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    exp_q.delete();
    m_cfg   = '0;
    do_push = 1'b0;
    do_pop  = 1'b0;
    #1;
    check("rst_enable_out", DW'(bus.enable_out), '0);
    check("rst_level", DW'(level), '0);
    check("rst_so_id", DW'(so_id), '0);
    check("rst_data_out", bus.data_out, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [TW-1:0] rid;
    rst           = 1'b1;
    se_id         = 1'b0;
    si_id         = 1'b0;
    m_cfg         = '0;
    bus.enable_in = 1'b0;
    bus.tag       = '0;
    bus.data_in   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("init_level", DW'(level), '0);
    check("init_enable_out", DW'(bus.enable_out), '0);
    check("init_data_out", bus.data_out, '0);
    check("init_so_id", DW'(so_id), '0);
    check("init_ready_out", DW'(bus.ready_out), DW'(1));
    rst = 1'b0;

    // unconfigured: everything dropped
    rdy_mode = 1;
    send(4'h5, 64'h1111);
    idle(3);

    // exact match on id 5
    scan(1'b1, 4'hF, 4'h5);
    send(4'h5, 64'hA5);
    send(4'h3, 64'h33);
    idle(3);

    // broadcast
    scan(1'b1, 4'h0, 4'h0);
    send(4'h0, 64'h100);
    send(4'h7, 64'h107);
    send(4'hF, 64'h10F);
    idle(4);

    // fill to full with downstream stalled, then release
    scan(1'b1, 4'hF, 4'h5);
    rdy_mode = 0;
    idle(1);
    for (int k = 0; k < DEPTH; k++) send(4'h5, 64'hD0 + DW'(k));
    fork
      send(4'h5, 64'hD0 + DW'(DEPTH));
      begin
        repeat (4) @(negedge clk);
        check("full_level", DW'(level), DW'(DEPTH));
        check("full_ready_out", DW'(bus.ready_out), '0);
        rdy_mode = 1;
      end
    join
    idle(DEPTH + 3);

    // scan while a packet is buffered and upstream is offering
    rdy_mode = 0;
    idle(1);
    send(4'h5, 64'hBEEF);
    bus.enable_in = 1'b1;
    bus.tag       = 4'h5;
    bus.data_in   = 64'hDEAD;
    fork
      scan(1'b1, 4'hF, 4'h5);
      begin
        @(negedge clk);
        check("scan_ready_out", DW'(bus.ready_out), '0);
        check("scan_level", DW'(level), DW'(1));
        repeat (3) @(posedge clk);
        rdy_mode = 1;
      end
    join
    bus.enable_in = 1'b0;
    idle(3);

    // random traffic with partial mask
    rid = 4'($urandom_range(0, 15));
    scan(1'b1, 4'b1010, rid);
    rdy_mode = 2;
    for (int p = 0; p < 1000; p++) begin
      idle($urandom_range(0, 2));
      send(4'($urandom_range(0, 15)), {$urandom, $urandom});
    end

    // reset in the middle of buffered traffic
    rdy_mode = 0;
    idle(1);
    scan(1'b1, 4'hF, 4'h5);
    send(4'h5, 64'h55);
    send(4'h5, 64'h66);
    do_reset();
    send(4'h5, 64'h77);
    rdy_mode = 1;
    idle(3);

    for (int n = 0; n < 50 && exp_q.size() != 0; n++) idle(1);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d packets still expected", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gon_mcc_buffered.md
Name: gon_mcc_buffered

Overview:
Parametrised multicast controller for the global-on-chip network (GON). Each incoming packet carries a tag. The tag is compared under a scan-configured mask against a scan-configured ID.
- Matching packets are queued in a small FIFO and forwarded downstream with a valid/ready handshake.
- Non-matching packets are acknowledged and dropped.
- The output is a driven bus, not tri-stated. The FIFO decouples downstream back-pressure from the shared GON bus.

Parameters:
DATA_WIDTH, 64, payload width in bits
TAG_WIDTH, 4, tag / ID / mask width in bits
FIFO_DEPTH, 2, number of buffered packets (>=1; need not be a power of two)

Ports:
link_clk  input  1  clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  DATA_WIDTH  upstream payload
tag  input  TAG_WIDTH  upstream destination tag, qualified by enable_in
enable_in  input  1  upstream valid
ready_out  output  1  upstream ready; a transfer occurs when enable_in & ready_out
data_out  output  DATA_WIDTH  FIFO head payload; all zeros when empty
enable_out  output  1  downstream valid (FIFO not empty)
ready_in  input  1  downstream ready; a pop occurs when enable_out & ready_in
se_id  input  1  scan enable for the configuration chain
si_id  input  1  scan serial in
so_id  output  1  scan serial out
level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (asynchronous, active-high):
  - cfg register = 0, FIFO empty, level = 0.
  - enable_out = 0, data_out = 0, so_id = 0.
  - ready_out follows the combinational rule below.
- Config register:
  - CFG_WIDTH = 2*TAG_WIDTH+1, laid out as {cfg_en, cfg_mask[TAG_WIDTH-1:0], cfg_id[TAG_WIDTH-1:0]}.
  - When se_id = 1, each cycle: cfg <= {si_id, cfg[CFG_WIDTH-1:1]}.
  - so_id = cfg[0], so the first bit shifted out is cfg_id[0].
  - When se_id = 0, cfg holds.
- Match rule:
  - match = cfg_en & ((tag & cfg_mask) == (cfg_id & cfg_mask)).
  - mask bit = 1 means "compare this bit"; mask = 0 with cfg_en = 1 means broadcast (always match).
- ready_out (combinational, no path from ready_in):
  - 0 while se_id = 1.
  - Otherwise 1 if !match.
  - Otherwise 1 if !full.
  - Otherwise 0.
- Push: enable_in & ready_out & match & !se_id. The pair {data_in} is written at the tail.
- Drop: enable_in & ready_out & !match. The packet is consumed; FIFO is unchanged.
- Pop: enable_out & ready_in. The head advances.
- Pops are permitted while se_id = 1.
- Simultaneous push and pop:
  - Allowed whenever not full; level unchanged.
  - When full, ready_out = 0, so no push occurs; the pop frees a slot visible next cycle.
- Latency: a packet pushed in cycle N appears on enable_out/data_out in cycle N+1 (registered FIFO storage, no fall-through).
- Order: packets leave strictly in arrival order (FIFO).
- Pointers:
  - Read and write pointers wrap from FIFO_DEPTH-1 to 0; non-power-of-two depth is handled by explicit compare, not modulo overflow.
  - full = (level == FIFO_DEPTH), empty = (level == 0).
- data_out = storage[rd_ptr] when !empty, else 0.
- Stability: enable_out and data_out must not change while enable_out & !ready_in.
- Reset mid-operation:
  - Buffered packets are discarded and cfg is cleared.
  - After reset the block drops all traffic (cfg_en = 0) until reconfigured.
- Scanning mid-traffic:
  - Intermediate cfg values are never used for pushes, because ready_out = 0 during se_id.

Test Plan:
- Scan in cfg_en=1, mask=4'hF, id=4'h5 (9 bits, LSB of id first). Send tag=5, data=64'hA5 with ready_in=1 -> enable_out=1 next cycle with data_out=64'hA5; level returns to 0.
- Same cfg, send tag=3 -> ready_out=1, packet consumed; enable_out stays 0; level=0.
- Mask=4'h0, cfg_en=1 -> tags 0, 7, F all forwarded in order. After reset with no scan, tag=5 is dropped.
- FIFO_DEPTH=2, ready_in=0, three matching packets D0/D1/D2 -> level=2 and ready_out=0 holding D2. Raise ready_in -> D0 then D1 then D2 out on consecutive cycles; no loss or duplication.
- DEPTH=3 with random ready_in/enable_in for 1000 packets -> output stream equals the matched input stream. Check wrap-around and the level bound 0..3.
- Assert se_id while level=1 and enable_in=1 -> ready_out=0 and no push; the buffered packet still drains. Assert reset mid-stream -> enable_out=0, level=0, so_id=0 immediately, asynchronously.
